vending_ctrl: RTL and testbench

Parametrised vending-machine controller, the multi-item, multi-denomination successor to the single-token fsm2 controller. It accumulates credit from coins of arbitrary value, vends one of `N_ITEMS` products at a fixed `PRICE`, and refunds change as a train of `CHANGE_UNIT` pulses. Sold-out, over-credit and invalid coins are rejected with a flash. It sits between the coin acceptor/keypad front end and the dispenser/change-hopper drivers.

---
 rtl/vending_ctrl.sv | 166 ++++++++++++++++
 tb/tb_vending_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl.sv
// ---------------------------------------------------------------------------
// vending_ctrl
//   Multi-item, multi-denomination vending-machine controller. Accumulates
//   credit from coins, vends one of N_ITEMS products at a fixed PRICE and
//   refunds the remainder as a train of CHANGE_UNIT pulses. Rejected coins
//   and bad selections produce a one-cycle flash. All outputs are registered.
//
// State table
//   state      | meaning
//   S_IDLE     | no credit; waiting for the first accepted coin
//   S_CREDIT   | credit > 0; accepting coins, selection or cancel
//   S_DISPENSE | drink asserted; waiting for received
//   S_REFUND   | one change pulse per cycle until credit reaches zero
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   coin_valid   in   a coin is presented this cycle
//   coin_value   in   value of the presented coin
//   cancel       in   refund request
//   sel_valid    in   a selection is made this cycle
//   sel_idx      in   selected item
//   stock_empty  in   per-item sold-out flags
//   received     in   customer has taken the drink
//   flash        out  one-cycle reject pulse
//   drink        out  dispense command, held until received
//   drink_idx    out  item being dispensed (valid while drink is high)
//   change       out  one pulse per CHANGE_UNIT refunded
//   credit       out  current credit
// ---------------------------------------------------------------------------
module vending_ctrl #(
    parameter int CREDIT_W    = 8,
    parameter int N_ITEMS     = 4,
    parameter int PRICE       = 150,
    parameter int CHANGE_UNIT = 25,
    parameter int MAX_CREDIT  = 200,
    localparam int IDX_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                cancel,
    input  logic                sel_valid,
    input  logic [IDX_W-1:0]    sel_idx,
    input  logic [N_ITEMS-1:0]  stock_empty,
    input  logic                received,
    output logic                flash,
    output logic                drink,
    output logic [IDX_W-1:0]    drink_idx,
    output logic                change,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);
    localparam logic [CREDIT_W:0]   MAX_EXT = (CREDIT_W + 1)'(MAX_CREDIT);
    // stock flags padded to the full index range so any sel_idx can be looked up
    localparam int NPAD = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_DISPENSE,
        S_REFUND
    } state_t;

    state_t                state_q;
    logic [CREDIT_W-1:0]   credit_q;
    logic                  flash_q;
    logic                  drink_q;
    logic [IDX_W-1:0]      drink_idx_q;
    logic                  change_q;

    logic [CREDIT_W:0]     coin_sum;
    logic                  coin_ok;
    logic [NPAD-1:0]       stock_pad;
    logic                  sel_in_range;
    logic                  sel_ok;

    // Sum at one extra bit so a large coin cannot wrap past the ceiling check.
    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};
    assign coin_ok  = (coin_value != '0)
                   && ((coin_value % UNIT_C) == '0)
                   && (coin_sum <= MAX_EXT);

    assign stock_pad    = NPAD'(stock_empty);
    assign sel_in_range = ({{(32 - IDX_W){1'b0}}, sel_idx} < 32'(N_ITEMS));
    assign sel_ok       = sel_in_range && !stock_pad[sel_idx] && (credit_q >= PRICE_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            credit_q    <= '0;
            flash_q     <= 1'b0;
            drink_q     <= 1'b0;
            drink_idx_q <= '0;
            change_q    <= 1'b0;
        end else begin
            flash_q  <= 1'b0;
            change_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (coin_valid) begin
                        if (coin_ok) begin
                            credit_q <= coin_value;
                            state_q  <= S_CREDIT;
                        end else begin
                            flash_q <= 1'b1;
                        end
                    end
                end
                S_CREDIT: begin
                    if (cancel) begin
                        state_q <= S_REFUND;
                        flash_q <= coin_valid;
                    end else if (sel_valid && sel_ok) begin
                        credit_q    <= credit_q - PRICE_C;
                        drink_q     <= 1'b1;
                        drink_idx_q <= sel_idx;
                        state_q     <= S_DISPENSE;
                        flash_q     <= coin_valid;
                    end else begin
                        // a rejected selection does not block a coin in the same cycle
                        if (coin_valid) begin
                            if (coin_ok) begin
                                credit_q <= coin_sum[CREDIT_W-1:0];
                            end else begin
                                flash_q <= 1'b1;
                            end
                        end
                        if (sel_valid) begin
                            flash_q <= 1'b1;
                        end
                    end
                end
                S_DISPENSE: begin
                    flash_q <= coin_valid;
                    if (received) begin
                        drink_q <= 1'b0;
                        state_q <= (credit_q == '0) ? S_IDLE : S_REFUND;
                    end
                end
                S_REFUND: begin
                    flash_q  <= coin_valid;
                    change_q <= 1'b1;
                    credit_q <= credit_q - UNIT_C;
                    // credit is always a multiple of the unit, so this is the last pulse
                    if (credit_q == UNIT_C) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign flash     = flash_q;
    assign drink     = drink_q;
    assign drink_idx = drink_idx_q;
    assign change    = change_q;
    assign credit    = credit_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vending_ctrl
//   Self-checking bench for vending_ctrl with default parameters. Runs a
//   table of directed vectors, a hand-written reset-during-refund sequence
//   and a randomized run compared against a behavioural credit model.
// ---------------------------------------------------------------------------
module tb_vending_ctrl;

    localparam int PRICE = 150;
    localparam int UNIT  = 25;
    localparam int MAXC  = 200;
    localparam int NIT   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [7:0] coin_value;
    logic       cancel;
    logic       sel_valid;
    logic [1:0] sel_idx;
    logic [3:0] stock_empty;
    logic       received;
    logic       flash;
    logic       drink;
    logic [1:0] drink_idx;
    logic       change;
    logic [7:0] credit;

    vending_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .coin_valid  (coin_valid),
        .coin_value  (coin_value),
        .cancel      (cancel),
        .sel_valid   (sel_valid),
        .sel_idx     (sel_idx),
        .stock_empty (stock_empty),
        .received    (received),
        .flash       (flash),
        .drink       (drink),
        .drink_idx   (drink_idx),
        .change      (change),
        .credit      (credit)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: credit as an integer plus two activity flags.
    int m_credit;
    bit m_disp, m_refund;
    bit m_flash, m_drink, m_change;
    int m_idx;

    task automatic model_reset();
        m_credit = 0; m_disp = 0; m_refund = 0;
        m_flash = 0; m_drink = 0; m_change = 0; m_idx = 0;
    endtask

    task automatic model_step();
        bit good;
        m_flash  = 0;
        m_change = 0;
        good = coin_valid && (coin_value != 0) && ((int'(coin_value) % UNIT) == 0)
               && (m_credit + int'(coin_value) <= MAXC);
        if (m_refund) begin
            m_change = 1;
            m_credit -= UNIT;
            if (m_credit == 0) m_refund = 0;
            m_flash = coin_valid;
        end else if (m_disp) begin
            m_flash = coin_valid;
            if (received) begin
                m_disp   = 0;
                m_drink  = 0;
                m_refund = (m_credit > 0);
            end
        end else if (m_credit == 0) begin
            if (coin_valid) begin
                if (good) m_credit = int'(coin_value);
                else      m_flash = 1;
            end
        end else if (cancel) begin
            m_refund = 1;
            m_flash  = coin_valid;
        end else if (sel_valid && int'(sel_idx) < NIT && !stock_empty[sel_idx] && m_credit >= PRICE) begin
            m_credit -= PRICE;
            m_disp  = 1;
            m_drink = 1;
            m_idx   = int'(sel_idx);
            m_flash = coin_valid;
        end else begin
            if (sel_valid) m_flash = 1;
            if (coin_valid) begin
                if (good) m_credit += int'(coin_value);
                else      m_flash = 1;
            end
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit cv, input int cval, input bit can, input bit sv,
                         input int idx, input int stk, input bit rcv);
        coin_valid  = cv;
        coin_value  = 8'(cval);
        cancel      = can;
        sel_valid   = sv;
        sel_idx     = 2'(idx);
        stock_empty = 4'(stk);
        received    = rcv;
    endtask

    typedef struct {
        bit cv; int coin; bit can; bit sv; int idx; int stk; bit rcv;
        bit ef; bit ed; int ei; bit ec; int ecr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit cv, int coin, bit can, bit sv, int idx, int stk, bit rcv,
                                bit ef, bit ed, int ei, bit ec, int ecr);
        vec_t v;
        v.cv = cv; v.coin = coin; v.can = can; v.sv = sv; v.idx = idx; v.stk = stk; v.rcv = rcv;
        v.ef = ef; v.ed = ed; v.ei = ei; v.ec = ec; v.ecr = ecr;
        return v;
    endfunction

    int coin_tab[8] = '{0, 25, 50, 75, 100, 125, 30, 200};

    initial begin
        // exact payment
        tbl.push_back(mk(1,100,0,0,0,0,0, 0,0,0,0,100));
        tbl.push_back(mk(1, 50,0,0,0,0,0, 0,0,0,0,150));
        tbl.push_back(mk(0,  0,0,1,2,0,0, 0,1,2,0,  0));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,1,2,0,  0));
        tbl.push_back(mk(0,  0,0,0,0,0,1, 0,0,0,0,  0));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,0,  0));
        // overpayment
        tbl.push_back(mk(1,100,0,0,0,0,0, 0,0,0,0,100));
        tbl.push_back(mk(1,100,0,0,0,0,0, 0,0,0,0,200));
        tbl.push_back(mk(0,  0,0,1,1,0,0, 0,1,1,0, 50));
        tbl.push_back(mk(0,  0,0,0,0,0,1, 0,0,0,0, 50));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1, 25));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1,  0));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,0,  0));
        // coin rejects then cancel
        tbl.push_back(mk(1,100,0,0,0,0,0, 0,0,0,0,100));
        tbl.push_back(mk(1,125,0,0,0,0,0, 1,0,0,0,100));
        tbl.push_back(mk(1, 30,0,0,0,0,0, 1,0,0,0,100));
        tbl.push_back(mk(0,  0,1,0,0,0,0, 0,0,0,0,100));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1, 75));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1, 50));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1, 25));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1,  0));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,0,  0));
        // bad selections
        tbl.push_back(mk(1,100,0,0,0,0,0, 0,0,0,0,100));
        tbl.push_back(mk(0,  0,0,1,0,0,0, 1,0,0,0,100));
        tbl.push_back(mk(1,100,0,0,0,0,0, 0,0,0,0,200));
        tbl.push_back(mk(0,  0,0,1,3,8,0, 1,0,0,0,200));
        tbl.push_back(mk(0,  0,0,1,0,8,0, 0,1,0,0, 50));
        tbl.push_back(mk(0,  0,0,0,0,0,1, 0,0,0,0, 50));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1, 25));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1,  0));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,0,  0));
        // cancel + selection + coin together
        tbl.push_back(mk(1,100,0,0,0,0,0, 0,0,0,0,100));
        tbl.push_back(mk(1, 50,0,0,0,0,0, 0,0,0,0,150));
        tbl.push_back(mk(1, 25,1,1,0,0,0, 1,0,0,0,150));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1,125));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1,100));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1, 75));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1, 50));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1, 25));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1,  0));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,0,  0));
        // idle ignores cancel/select/received; zero coin; ceiling; coin during vend/dispense
        tbl.push_back(mk(0,  0,1,1,0,0,1, 0,0,0,0,  0));
        tbl.push_back(mk(1,  0,0,0,0,0,0, 1,0,0,0,  0));
        tbl.push_back(mk(1,200,0,0,0,0,0, 0,0,0,0,200));
        tbl.push_back(mk(1, 25,0,0,0,0,0, 1,0,0,0,200));
        tbl.push_back(mk(1, 25,0,1,1,0,0, 1,1,1,0, 50));
        tbl.push_back(mk(1, 25,0,0,0,0,0, 1,1,1,0, 50));
        tbl.push_back(mk(0,  0,0,0,0,0,1, 0,0,0,0, 50));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1, 25));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,1,  0));
        tbl.push_back(mk(0,  0,0,0,0,0,0, 0,0,0,0,  0));

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        chk("reset flash",  int'(flash),  0);
        chk("reset drink",  int'(drink),  0);
        chk("reset idx",    int'(drink_idx), 0);
        chk("reset change", int'(change), 0);
        chk("reset credit", int'(credit), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].cv, tbl[i].coin, tbl[i].can, tbl[i].sv, tbl[i].idx, tbl[i].stk, tbl[i].rcv);
            step_clk();
            chk($sformatf("row%0d flash", i),  int'(flash),  int'(tbl[i].ef));
            chk($sformatf("row%0d drink", i),  int'(drink),  int'(tbl[i].ed));
            chk($sformatf("row%0d change", i), int'(change), int'(tbl[i].ec));
            chk($sformatf("row%0d credit", i), int'(credit), tbl[i].ecr);
            if (tbl[i].ed) chk($sformatf("row%0d drink_idx", i), int'(drink_idx), tbl[i].ei);
        end

        // reset asserted between edges during the third change pulse
        drive(1, 100, 0, 0, 0, 0, 0);
        step_clk();
        chk("rst-seq credit", int'(credit), 100);
        drive(0, 0, 1, 0, 0, 0, 0);
        step_clk();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            step_clk();
            chk($sformatf("rst-seq pulse%0d change", k), int'(change), 1);
            chk($sformatf("rst-seq pulse%0d credit", k), int'(credit), 100 - 25 * k);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid-refund reset change", int'(change), 0);
        chk("mid-refund reset credit", int'(credit), 0);
        chk("mid-refund reset flash",  int'(flash),  0);
        chk("mid-refund reset drink",  int'(drink),  0);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step_clk();
            chk($sformatf("post-reset change%0d", k), int'(change), 0);
            chk($sformatf("post-reset credit%0d", k), int'(credit), 0);
        end
        drive(1, 50, 0, 0, 0, 0, 0);
        step_clk();
        chk("post-reset idle coin credit", int'(credit), 50);
        chk("post-reset idle coin flash",  int'(flash),  0);

        // randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 9) < 4),
                  coin_tab[$urandom_range(0, 7)],
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0,
                  ($urandom_range(0, 9) < 3));
            step_clk();
            chk($sformatf("rand%0d flash", n),  int'(flash),  int'(m_flash));
            chk($sformatf("rand%0d drink", n),  int'(drink),  int'(m_drink));
            chk($sformatf("rand%0d change", n), int'(change), int'(m_change));
            chk($sformatf("rand%0d credit", n), int'(credit), m_credit);
            if (m_drink) chk($sformatf("rand%0d drink_idx", n), int'(drink_idx), m_idx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
